// File: rtl/fetch_instrucciones_if.sv
// Fetch-stage bus: instruction-memory req/ack channel and decoder valid/ready channel.
interface fetch_instrucciones_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] TR;
   logic [31:0] pc_tr;
   logic        tr_valid;
   logic        tr_ready;

   // Fetch stage side: issues memory requests and presents instructions.
   modport master (
      output mem_req, mem_addr, TR, pc_tr, tr_valid,
      input  mem_ack, mem_rdata, tr_ready
   );

   // Memory/decoder side.
   modport slave (
      input  mem_req, mem_addr, TR, pc_tr, tr_valid,
      output mem_ack, mem_rdata, tr_ready
   );
endinterface

// File: rtl/fetch_instrucciones.sv
// Instruction fetch stage: PC, one-outstanding-request memory handshake,
// small instruction FIFO towards the R-type decoder, halt and flush/redirect.
module fetch_instrucciones #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         halt,
   input  logic                         flush,
   input  logic [31:0]                  flush_pc,
   fetch_instrucciones_if.master        bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   // IDLE: nothing outstanding; REQ: request whose data is kept;
   // DRAIN: request whose data must be thrown away after a flush.
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t        state_reg, state_next;
   logic [31:0]   pc_reg, pc_next;
   logic [31:0]   addr_reg, addr_next;
   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_after_pop;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [31:0]   instr_reg [DEPTH];
   logic [31:0]   ipc_reg   [DEPTH];

   assign fifo_empty      = (count_reg == '0);
   // flush wins over both FIFO ports in its cycle.
   assign push            = (state_reg == REQ) && bus.mem_ack && !flush;
   assign pop             = !fifo_empty && bus.tr_ready && !flush;
   assign count_after_pop = count_reg - (pop ? CNT_ONE : '0);

   // Decoder side reads straight out of the storage registers; zero when empty.
   assign bus.tr_valid = !fifo_empty;
   assign bus.TR       = fifo_empty ? 32'h0 : instr_reg[rd_ptr_reg];
   assign bus.pc_tr    = fifo_empty ? 32'h0 : ipc_reg[rd_ptr_reg];

   // State, program counter and the address held during DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         addr_reg  <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         addr_reg  <= addr_next;
      end
   end

   // Next state, next PC and memory request outputs.
   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      addr_next    = addr_reg;
      bus.mem_req  = 1'b0;
      bus.mem_addr = pc_reg;
      case (state_reg)
         IDLE: begin
            // Issue only if the returning word is guaranteed a free slot.
            if (!flush && !halt && (count_after_pop < FULL_CNT))
               state_next = REQ;
         end
         REQ: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
               state_next = IDLE;
               if (!flush)
                  pc_next = pc_reg + 32'd4;
            end else if (flush) begin
               // Keep presenting the old address until memory answers.
               state_next = DRAIN;
               addr_next  = pc_reg;
            end
         end
         DRAIN: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = addr_reg;
            if (bus.mem_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Redirect target is always word aligned.
      if (flush)
         pc_next = flush_pc & 32'hFFFF_FFFC;
   end

   // FIFO pointers and occupancy; flush empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (push && !pop)
            count_reg <= count_reg + CNT_ONE;
         else if (pop && !push)
            count_reg <= count_reg - CNT_ONE;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the acknowledged word and its fetch address into this slot.
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_reg == AW'(gi))) begin
            instr_reg[gi] <= bus.mem_rdata;
            ipc_reg[gi]   <= pc_reg;
         end
      end
   end
endmodule

// File: tb/tb_fetch_instrucciones.sv
// Directed bench for fetch_instrucciones with a queue-based reference model.
module tb_fetch_instrucciones;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halt = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;
   logic        tr_ready_drv = 1'b0;
   logic        ack_drv = 1'b0;
   logic [31:0] rdata_drv = 32'h0;
   logic        w_halt = 1'b0;
   logic        w_flush = 1'b0;
   logic [31:0] w_flush_pc = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   fetch_instrucciones_if bus();
   fetch_instrucciones_if wbus();

   assign bus.mem_ack   = ack_drv;
   assign bus.mem_rdata = rdata_drv;
   assign bus.tr_ready  = tr_ready_drv;

   // Second instance only exercises PC wrap-around: instant ack, always ready.
   assign wbus.mem_ack   = wbus.mem_req;
   assign wbus.mem_rdata = ~wbus.mem_addr;
   assign wbus.tr_ready  = 1'b1;

   fetch_instrucciones #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
      .flush_pc(flush_pc), .bus(bus.master)
   );

   fetch_instrucciones #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .halt(w_halt), .flush(w_flush),
      .flush_pc(w_flush_pc), .bus(wbus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // ---------------- instruction memory responder ----------------
   logic [31:0] imem [64];
   int lat = 0;
   int wait_cnt = 0;
   bit spurious = 1'b0;

   always @(posedge clk) begin
      #2;
      if (rst_n && bus.mem_req) begin
         if (wait_cnt >= lat) begin
            ack_drv   = 1'b1;
            rdata_drv = imem[bus.mem_addr[7:2]];
            wait_cnt  = 0;
         end else begin
            ack_drv   = 1'b0;
            rdata_drv = 32'hDEAD_BEEF;
            wait_cnt++;
         end
      end else begin
         ack_drv   = rst_n && spurious;
         rdata_drv = 32'hBAD0_BAD0;
         wait_cnt  = 0;
      end
   end

   // ---------------- reference model ----------------
   bit          m_busy;
   bit          m_drop;
   logic [31:0] m_pc;
   logic [31:0] m_req_addr;
   logic [63:0] m_q[$];

   task automatic model_reset();
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_pc = 32'h0;
      m_req_addr = 32'h0;
      m_q.delete();
   endtask

   // Advance the model across the coming rising edge using current inputs.
   task automatic model_step();
      bit do_pop;
      logic [63:0] dummy;
      do_pop = (m_q.size() != 0) && bus.tr_ready && !flush;
      if (flush) begin
         m_q.delete();
         if (m_busy) begin
            if (bus.mem_ack) begin
               m_busy = 1'b0;
               m_drop = 1'b0;
            end else begin
               m_drop = 1'b1;
            end
         end
         m_pc = {flush_pc[31:2], 2'b00};
      end else begin
         if (do_pop) dummy = m_q.pop_front();
         if (m_busy) begin
            if (bus.mem_ack) begin
               if (!m_drop) begin
                  m_q.push_back({m_req_addr, bus.mem_rdata});
                  m_pc = m_pc + 32'd4;
               end
               m_busy = 1'b0;
               m_drop = 1'b0;
            end
         end else if (!halt && m_q.size() < DEPTH) begin
            m_busy = 1'b1;
            m_req_addr = m_pc;
         end
      end
   endtask

   initial model_reset();

   // Per-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("tr_valid", bus.tr_valid, m_q.size() != 0);
      chk("mem_req", bus.mem_req, m_busy);
      if (m_busy) chk("mem_addr", bus.mem_addr, m_req_addr);
      if (!rst_n) chk("reset_mem_addr", bus.mem_addr, 32'h0);
      if (m_q.size() != 0) begin
         chk("TR", bus.TR, m_q[0][31:0]);
         chk("pc_tr", bus.pc_tr, m_q[0][63:32]);
      end else begin
         chk("TR_empty", bus.TR, 32'h0);
         chk("pc_tr_empty", bus.pc_tr, 32'h0);
      end
      if (rst_n) model_step();
   end

   // ---------------- observation ----------------
   logic [63:0] popped[$];
   logic [31:0] wrap_addrs[$];
   int req_cycles = 0;

   always @(negedge clk) begin
      if (rst_n && bus.tr_valid && bus.tr_ready && !flush)
         popped.push_back({bus.pc_tr, bus.TR});
      if (rst_n && bus.mem_req)
         req_cycles++;
      if (rst_n && wbus.mem_req)
         wrap_addrs.push_back(wbus.mem_addr);
   end

   function automatic logic [63:0] get_pop(input int i);
      return (popped.size() > i) ? popped[i] : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic [31:0] get_wrap(input int i);
      return (wrap_addrs.size() > i) ? wrap_addrs[i] : 32'h1234_5678;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      halt = 1'b0;
      flush = 1'b0;
      spurious = 1'b0;
      tr_ready_drv = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      popped.delete();
      req_cycles = 0;
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k = 0;
      while (popped.size() < n && k < budget) begin
         cyc(1);
         k++;
      end
      chk(name, popped.size() >= n, 1'b1);
   endtask

   task automatic wait_req(input bit need_valid, input string name);
      int k = 0;
      while (!(bus.mem_req && (!need_valid || bus.tr_valid)) && k < 40) begin
         cyc(1);
         k++;
      end
      chk(name, bus.mem_req && (!need_valid || bus.tr_valid), 1'b1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [63:0] e;
      for (int i = 0; i < 64; i++) imem[i] = 32'h0200_0000 + 32'(i);

      // 1: back-to-back fetch with immediate ack
      lat = 0;
      imem[0] = 32'h0149_5020;
      imem[1] = 32'h0149_5022;
      do_reset();
      tr_ready_drv = 1'b1;
      wait_pops(2, 20, "t1_pops");
      chk("t1_word0", get_pop(0), {32'h0, 32'h0149_5020});
      chk("t1_word1", get_pop(1), {32'h4, 32'h0149_5022});

      // 2: decoder stalled, FIFO fills and fetching stops
      imem[0] = 32'h0149_5024;
      imem[1] = 32'h0064_2825;
      do_reset();
      cyc(10);
      chk("t2_valid", bus.tr_valid, 1'b1);
      chk("t2_TR_held", bus.TR, 32'h0149_5024);
      chk("t2_pc_held", bus.pc_tr, 32'h0);
      chk("t2_no_req", bus.mem_req, 1'b0);
      tr_ready_drv = 1'b1;
      wait_pops(3, 20, "t2_pops");
      chk("t2_word0", get_pop(0), {32'h0, 32'h0149_5024});
      chk("t2_word1", get_pop(1), {32'h4, 32'h0064_2825});
      e = get_pop(2);
      chk("t2_resume_pc", e[63:32], 32'h8);

      // 3: three-cycle ack latency
      lat = 2;
      do_reset();
      tr_ready_drv = 1'b1;
      wait_pops(2, 40, "t3_pops");
      chk("t3_word0", get_pop(0), {32'h0, 32'h0149_5024});
      chk("t3_word1", get_pop(1), {32'h4, 32'h0064_2825});
      chk("t3_req_cycles", req_cycles, 6);

      // 4: flush to 0x40 with one word buffered and a request to 0x8 in flight
      lat = 0;
      do_reset();
      cyc(8);
      lat = 2;
      tr_ready_drv = 1'b1;
      cyc(1);
      tr_ready_drv = 1'b0;
      chk("t4_pre_req", bus.mem_req, 1'b1);
      chk("t4_pre_addr", bus.mem_addr, 32'h8);
      chk("t4_pre_valid", bus.tr_valid, 1'b1);
      flush = 1'b1;
      flush_pc = 32'h0000_0043;
      cyc(1);
      flush = 1'b0;
      chk("t4_valid_cleared", bus.tr_valid, 1'b0);
      chk("t4_drain_req", bus.mem_req, 1'b1);
      chk("t4_drain_addr", bus.mem_addr, 32'h8);
      tr_ready_drv = 1'b1;
      popped.delete();
      wait_pops(1, 40, "t4_pops");
      e = get_pop(0);
      chk("t4_first_pc", e[63:32], 32'h40);
      chk("t4_first_word", e[31:0], imem[16]);

      // 5: halt mid-request, stray acks while idle
      lat = 2;
      do_reset();
      tr_ready_drv = 1'b1;
      wait_req(1'b0, "t5_first_req");
      halt = 1'b1;
      spurious = 1'b1;
      cyc(12);
      chk("t5_no_req", bus.mem_req, 1'b0);
      chk("t5_one_word", popped.size(), 1);
      e = get_pop(0);
      chk("t5_word_pc", e[63:32], 32'h0);
      halt = 1'b0;
      spurious = 1'b0;
      wait_pops(2, 40, "t5_pops");
      e = get_pop(1);
      chk("t5_resume_pc", e[63:32], 32'h4);

      // 6: PC wrap on the second instance, then reset in the middle of a request
      lat = 2;
      do_reset();
      wrap_addrs.delete();
      cyc(6);
      chk("t6_wrap_addr0", get_wrap(0), 32'hFFFF_FFFC);
      chk("t6_wrap_addr1", get_wrap(1), 32'h0000_0000);
      wait_req(1'b1, "t6_req_and_valid");
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", bus.mem_req, 1'b0);
      chk("t6_rst_valid", bus.tr_valid, 1'b0);
      chk("t6_rst_TR", bus.TR, 32'h0);
      cyc(2);
      rst_n = 1'b1;
      tr_ready_drv = 1'b1;
      cyc(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
